ov7670_pattern_tx: RTL and testbench



---
 rtl/ov7670_pattern_tx_if.sv | 9 +
 rtl/ov7670_pattern_tx.sv | 164 ++++++++++++++++
 tb/tb_ov7670_pattern_tx.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ov7670_pattern_tx_if.sv
// OV7670 camera-side video bus: vsync, href and the 8-bit byte stream on pclk.
interface ov7670_pattern_tx_if;
   logic       vsync;
   logic       href;
   logic [7:0] d;

   modport master (output vsync, href, d);
   modport slave  (input  vsync, href, d);
endinterface

// File: rtl/ov7670_pattern_tx.sv
// OV7670 sensor emulator: generates camera-timed frames of RGB565 test patterns on pclk.
module ov7670_pattern_tx #(
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned H_BLANK     = 144,
   parameter int unsigned VSYNC_LINES = 3,
   parameter int unsigned V_BACK      = 17,
   parameter int unsigned V_FRONT     = 10
) (
   input  logic                       pclk,
   input  logic                       reset_n,
   input  logic                       enable,
   input  logic [1:0]                 mode,
   input  logic [11:0]                solid_rgb,
   ov7670_pattern_tx_if.master        cam,
   output logic                       frame_start,
   output logic [7:0]                 frame_count
);

   localparam int unsigned LINE_LEN  = 2 * H_ACTIVE + H_BLANK;
   localparam logic [15:0] HCNT_LAST = 16'(LINE_LEN - 1);
   localparam logic [15:0] HREF_END  = 16'(2 * H_ACTIVE);
   localparam logic [15:0] BAR_LAST  = 16'(H_ACTIVE / 4 - 1);
   localparam logic [15:0] VS_LAST   = 16'(VSYNC_LINES - 1);
   localparam logic [15:0] VB_LAST   = 16'(V_BACK - 1);
   localparam logic [15:0] VA_LAST   = 16'(V_ACTIVE - 1);
   localparam logic [15:0] VF_LAST   = 16'(V_FRONT - 1);

   typedef enum logic [2:0] {StIdle, StVsync, StVback, StActive, StVfront} state_t;

   state_t      state_q, state_d, state_after;
   logic [15:0] hcnt_q, hcnt_d;
   logic [15:0] line_q, line_d, line_last;
   logic [15:0] bar_px_q, bar_px_d;
   logic [2:0]  bar_idx_q, bar_idx_d;
   logic [7:0]  fcnt_q, fcnt_d;
   logic [1:0]  mode_q, mode_d;
   logic [11:0] rgb_q, rgb_d;
   logic        line_end, enter;
   logic        vsync_q, href_q, href_d, fstart_q;
   logic [7:0]  d_q, d_d;
   logic [15:0] pix;
   logic [3:0]  gray;

   assign cam.vsync   = vsync_q;
   assign cam.href    = href_q;
   assign cam.d       = d_q;
   assign frame_start = fstart_q;
   assign frame_count = fcnt_q;

   // Timing: hcnt runs every cycle outside IDLE, line counts restart in each state.
   always_comb begin
      line_end    = (hcnt_q == HCNT_LAST);
      state_d     = state_q;
      hcnt_d      = hcnt_q;
      line_d      = line_q;
      fcnt_d      = fcnt_q;
      mode_d      = mode_q;
      rgb_d       = rgb_q;
      enter       = 1'b0;
      line_last   = '0;
      state_after = StIdle;
      case (state_q)
         StVsync:  begin line_last = VS_LAST; state_after = StVback;  end
         StVback:  begin line_last = VB_LAST; state_after = StActive; end
         StActive: begin line_last = VA_LAST; state_after = StVfront; end
         StVfront: begin line_last = VF_LAST; state_after = enable ? StVsync : StIdle; end
         default: ;
      endcase
      if (state_q == StIdle) begin
         if (enable) begin
            state_d = StVsync;
            line_d  = '0;
            enter   = 1'b1;
         end
      end else begin
         hcnt_d = line_end ? '0 : hcnt_q + 16'd1;
         if (line_end) begin
            if (line_q == line_last) begin
               line_d  = '0;
               state_d = state_after;
               if (state_q == StVfront) begin
                  fcnt_d = fcnt_q + 8'd1;
                  enter  = enable;
               end
            end else begin
               line_d = line_q + 16'd1;
            end
         end
      end
      if (enter) begin
         mode_d = mode;
         rgb_d  = solid_rgb;
      end
   end

   // Colour-bar index tracks hcnt_d so no divider is needed.
   always_comb begin
      bar_px_d  = bar_px_q + 16'd1;
      bar_idx_d = bar_idx_q;
      if (hcnt_d == '0) begin
         bar_px_d  = '0;
         bar_idx_d = '0;
      end else if (bar_px_q == BAR_LAST) begin
         bar_px_d  = '0;
         bar_idx_d = bar_idx_q + 3'd1;
      end
   end

   // Pixel for the position shown after the next edge; hcnt_d[8:1] is x[7:0].
   always_comb begin
      gray = hcnt_d[8:5];
      case (mode_d)
         2'd0: begin
            case (bar_idx_d)
               3'd0:    pix = 16'hFFFF;
               3'd1:    pix = 16'hFFE0;
               3'd2:    pix = 16'h07FF;
               3'd3:    pix = 16'h07E0;
               3'd4:    pix = 16'hF81F;
               3'd5:    pix = 16'hF800;
               3'd6:    pix = 16'h001F;
               default: pix = 16'h0000;
            endcase
         end
         2'd1:    pix = {gray, 1'b0, gray, 2'b00, gray, 1'b0};
         2'd2:    pix = (hcnt_d[6] ^ line_d[5]) ? 16'hFFFF : 16'h0000;
         default: pix = {rgb_d[11:8], 1'b0, rgb_d[7:4], 2'b00, rgb_d[3:0], 1'b0};
      endcase
      href_d = (state_d == StActive) && (hcnt_d < HREF_END);
      d_d    = href_d ? (hcnt_d[0] ? pix[7:0] : pix[15:8]) : 8'h00;
   end

   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         hcnt_q    <= '0;
         line_q    <= '0;
         bar_px_q  <= '0;
         bar_idx_q <= '0;
         fcnt_q    <= '0;
         mode_q    <= '0;
         rgb_q     <= '0;
         vsync_q   <= 1'b0;
         href_q    <= 1'b0;
         fstart_q  <= 1'b0;
         d_q       <= 8'h00;
      end else begin
         state_q   <= state_d;
         hcnt_q    <= hcnt_d;
         line_q    <= line_d;
         bar_px_q  <= bar_px_d;
         bar_idx_q <= bar_idx_d;
         fcnt_q    <= fcnt_d;
         mode_q    <= mode_d;
         rgb_q     <= rgb_d;
         vsync_q   <= (state_d == StVsync);
         href_q    <= href_d;
         fstart_q  <= enter;
         d_q       <= d_d;
      end
   end

endmodule

// File: tb/tb_ov7670_pattern_tx.sv
// Scoreboard bench for ov7670_pattern_tx: frame-position reference model vs. the DUT byte stream.
module tb_ov7670_pattern_tx;

   localparam int unsigned HA = 16, VA = 4, HB = 4, VSL = 1, VB = 1, VF = 1;
   localparam int unsigned LL    = 2 * HA + HB;
   localparam int unsigned FRAME = LL * (VSL + VB + VA + VF);

   logic        pclk = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [11:0] solid_rgb = 12'h000;
   logic        frame_start;
   logic [7:0]  frame_count;

   ov7670_pattern_tx_if cam ();

   ov7670_pattern_tx #(
      .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
      .VSYNC_LINES(VSL), .V_BACK(VB), .V_FRONT(VF)
   ) dut (
      .pclk(pclk),
      .reset_n(reset_n),
      .enable(enable),
      .mode(mode),
      .solid_rgb(solid_rgb),
      .cam(cam),
      .frame_start(frame_start),
      .frame_count(frame_count)
   );

   always #5 pclk = ~pclk;

   typedef struct packed {
      logic       vsync;
      logic       href;
      logic [7:0] d;
      logic       fs;
      logic [7:0] fc;
   } obs_t;

   obs_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                             16'hF81F, 16'hF800, 16'h001F, 16'h0000};

   bit          m_run = 1'b0;
   int unsigned m_t = 0;
   logic [1:0]  m_mode = 2'd0;
   logic [11:0] m_rgb = 12'h000;
   logic [7:0]  m_fc = 8'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, req);
      end
   endtask

   function automatic logic [7:0] model_byte(input logic [1:0] m, input logic [11:0] rgb,
                                             input int unsigned x, input int unsigned y,
                                             input bit hi);
      logic [15:0] pix;
      logic [3:0]  l;
      l = 4'((x >> 4) & 15);
      case (m)
         2'd0:    pix = bars[x / (HA / 8)];
         2'd1:    pix = {l, 1'b0, l, 2'b00, l, 1'b0};
         2'd2:    pix = (((x >> 5) ^ (y >> 5)) & 1) != 0 ? 16'hFFFF : 16'h0000;
         default: pix = {rgb[11:8], 1'b0, rgb[7:4], 2'b00, rgb[3:0], 1'b0};
      endcase
      return hi ? pix[15:8] : pix[7:0];
   endfunction

   // Outputs expected tt cycles into a frame, from line/column arithmetic.
   function automatic obs_t expect_at(input bit run, input int unsigned tt, input logic [1:0] m,
                                      input logic [11:0] rgb, input logic [7:0] fc);
      obs_t        o;
      int unsigned line, col;
      o    = '0;
      o.fc = fc;
      if (run) begin
         line    = tt / LL;
         col     = tt % LL;
         o.vsync = (line < VSL);
         o.fs    = (tt == 0);
         if (line >= VSL + VB && line < VSL + VB + VA && col < 2 * HA) begin
            o.href = 1'b1;
            o.d    = model_byte(m, rgb, col / 2, line - VSL - VB, (col % 2) == 0);
         end
      end
      return o;
   endfunction

   // Reference model: advances at each edge and queues what the DUT must show next.
   initial begin
      forever begin
         @(posedge pclk);
         if (!reset_n) begin
            m_run = 1'b0;
            m_t   = 0;
            m_fc  = 8'd0;
         end else if (!m_run) begin
            if (enable) begin
               m_run  = 1'b1;
               m_t    = 0;
               m_mode = mode;
               m_rgb  = solid_rgb;
            end
         end else begin
            m_t++;
            if (m_t == FRAME) begin
               m_fc++;
               m_t = 0;
               if (enable) begin
                  m_mode = mode;
                  m_rgb  = solid_rgb;
               end else begin
                  m_run = 1'b0;
               end
            end
         end
         exp_q.push_back(expect_at(m_run, m_t, m_mode, m_rgb, m_fc));
      end
   end

   initial begin
      obs_t e, a;
      forever begin
         @(negedge pclk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {cam.vsync, cam.href, cam.d, frame_start, frame_count};
            check("stream", 32'(a), 32'(e));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge pclk);
         #2;
      end
   endtask

   task automatic rand_cycles(input int n);
      repeat (n) begin
         step(1);
         if ($urandom_range(15) == 0) begin
            mode      = 2'($urandom_range(3));
            solid_rgb = 12'($urandom);
         end
      end
   endtask

   // Asynchronous reset: the expectation already queued for this cycle becomes all-zero.
   task automatic reset_assert();
      reset_n = 1'b0;
      #1;
      exp_q.delete();
      exp_q.push_back('0);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_vsync"}, 32'(cam.vsync), 32'd0);
      check({tag, "_href"}, 32'(cam.href), 32'd0);
      check({tag, "_d"}, 32'(cam.d), 32'd0);
      check({tag, "_fcount"}, 32'(frame_count), 32'd0);
   endtask

   initial begin
      logic [7:0]  hi;
      logic [15:0] pix;
      bit          have;
      bit          seen;

      #1;
      step(2);
      check_idle_outputs("reset");
      check("reset_fstart", 32'(frame_start), 32'd0);
      reset_n = 1'b1;
      step(1);

      // Colour bars, one enable pulse spanning a frame boundary.
      mode   = 2'd0;
      enable = 1'b1;
      step(1);
      check("first_vsync", 32'(cam.vsync), 32'd1);
      check("first_fstart", 32'(frame_start), 32'd1);
      step(1);
      check("fstart_single", 32'(frame_start), 32'd0);
      step(FRAME - 1);
      check("fcount_after_frame1", 32'(frame_count), 32'd1);
      enable = 1'b0;
      step(FRAME + 4);

      // Solid colour recovered through the capture bit selection.
      reset_assert();
      step(2);
      reset_n   = 1'b1;
      mode      = 2'd3;
      solid_rgb = 12'hA5C;
      enable    = 1'b1;
      have      = 1'b0;
      repeat (FRAME + 4) begin
         @(negedge pclk);
         if (cam.href) begin
            if (!have) begin
               hi   = cam.d;
               have = 1'b1;
            end else begin
               pix  = {hi, cam.d};
               have = 1'b0;
               check("capture_rgb", 32'({pix[15:12], pix[10:7], pix[4:1]}), 32'h0A5C);
            end
         end
      end
      @(posedge pclk);
      #2;
      enable = 1'b0;
      step(2 * FRAME);

      // Three full frames, enable dropped 100 cycles into the fourth.
      reset_assert();
      step(2);
      reset_n = 1'b1;
      enable  = 1'b1;
      step(1);
      rand_cycles(3 * FRAME + 100);
      enable = 1'b0;
      rand_cycles(FRAME);
      check("fcount_after_drop", 32'(frame_count), 32'd4);
      seen = 1'b0;
      repeat (300) begin
         @(negedge pclk);
         if (cam.vsync || cam.href) seen = 1'b1;
      end
      check("quiet_after_drop", 32'(seen), 32'd0);
      @(posedge pclk);
      #2;

      // Mode change mid-frame takes effect only from the next frame.
      reset_assert();
      step(2);
      reset_n = 1'b1;
      mode    = 2'd0;
      enable  = 1'b1;
      step(101);
      mode = 2'd2;
      step(FRAME - 100);
      step(FRAME);
      enable = 1'b0;
      step(FRAME);

      // Asynchronous reset during active line 2 of the third frame.
      reset_assert();
      step(2);
      reset_n = 1'b1;
      mode    = 2'd0;
      enable  = 1'b1;
      step(1);
      step(2 * FRAME + (VSL + VB + 2) * LL + 5);
      check("href_before_reset", 32'(cam.href), 32'd1);
      check("fcount_before_reset", 32'(frame_count), 32'd2);
      reset_assert();
      check_idle_outputs("async_reset");
      step(2);
      reset_n = 1'b1;
      step(1);
      check("vsync_after_release", 32'(cam.vsync), 32'd1);

      // 256 back-to-back frames wrap the frame counter.
      rand_cycles(255 * FRAME);
      check("fcount_255", 32'(frame_count), 32'd255);
      rand_cycles(FRAME);
      check("fcount_wrap", 32'(frame_count), 32'd0);
      check("b2b_vsync", 32'(cam.vsync), 32'd1);
      check("b2b_fstart", 32'(frame_start), 32'd1);
      enable = 1'b0;
      step(FRAME + 4);
      check("queue_drained", 32'(exp_q.size() <= 1), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
